comp_reset_req: RTL and testbench

Initiator side of the reset controller's watchdog/soft-reset interface. It generates the periodic watchdog kick on wdi and sequences software-requested resets on soft_rst_n. It monitors the controller's rst_n to confirm each reset request was honoured and then released. It sits in the clocked system domain and drives the wdi/soft_rst_n inputs of the reset controller.

---
 rtl/comp_reset_pkg.sv | 16 +
 rtl/comp_sync2.sv | 21 ++
 rtl/comp_reset_req.sv | 126 ++++++++++++
 tb/tb_comp_reset_req.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/comp_reset_pkg.sv
// Shared types and default timing constants for the soft-reset / watchdog-kick initiator.
package comp_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  localparam int unsigned KICK_PERIOD_DEF = 500;
  localparam int unsigned SRST_WIDTH_DEF  = 10;
  localparam int unsigned ACK_TIMEOUT_DEF = 1000;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/comp_sync2.sv
// Two-flop synchroniser for an asynchronous level; resets to 1 (inactive for active-low inputs).
module comp_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/comp_reset_req.sv
// Watchdog kick generator and soft-reset request sequencer toward the reset controller.
module comp_reset_req
  import comp_reset_pkg::*;
#(
  parameter int unsigned KICK_PERIOD = KICK_PERIOD_DEF,
  parameter int unsigned SRST_WIDTH  = SRST_WIDTH_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_kick,
  input  logic kick_req,
  input  logic srst_req,
  input  logic rst_n,
  output logic wdi,
  output logic soft_rst_n,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [CNT_W-1:0] KICK_LAST = CNT_W'(KICK_PERIOD - 1);
  localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SRST_WIDTH - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_n_s;
  logic             wdi_d, soft_rst_n_d, busy_d, done_d, err_d;

  comp_sync2 u_sync_rst_n (
    .clk (clk),
    .rst (rst),
    .d   (rst_n),
    .q   (rst_n_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wdi        <= 1'b0;
      soft_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdi        <= wdi_d;
      soft_rst_n <= soft_rst_n_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // One counter serves kick period, assert width and ack timeout, since they never overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdi_d   = wdi;
    err_d   = err;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (srst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (en_kick && rst_n_s) begin
          if (kick_req || (cnt_q == KICK_LAST)) begin
            wdi_d = ~wdi;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      ST_ASSERT: begin
        if (cnt_q == SRST_LAST) begin
          // A controller already in reset skips straight to waiting for release.
          state_d = rst_n_s ? ST_WAIT_ACK : ST_WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_ACK: begin
        if (!rst_n_s) begin
          state_d = ST_WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == ACK_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_REL: begin
        if (rst_n_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    soft_rst_n_d = (state_d != ST_ASSERT);
    busy_d       = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_comp_reset_req.sv
// Directed vector table for watchdog kicking plus hand-written soft-reset sequences.
module tb_comp_reset_req;

  localparam int SW = 10;
  localparam int AT = 1000;
  localparam int NV = 22;

  logic clk = 1'b0;
  logic rst, en_kick, kick_req, srst_req, rst_n;
  logic wdi, soft_rst_n, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  // exp = {wdi, soft_rst_n, busy, done, err}
  typedef struct {
    logic       en_kick;
    logic       kick_req;
    logic       srst_req;
    logic       rst_n;
    int         cycles;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [NV];

  comp_reset_req dut (
    .clk        (clk),
    .rst        (rst),
    .en_kick    (en_kick),
    .kick_req   (kick_req),
    .srst_req   (srst_req),
    .rst_n      (rst_n),
    .wdi        (wdi),
    .soft_rst_n (soft_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {wdi, soft_rst_n, busy, done, err};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {wdi,soft_rst_n,busy,done,err} got %b expected %b", name, act, exp);
    end
  endtask

  // srst_req issued now; rst_n model goes low after cycle low_at and high after high_at
  // (low_at < 0: controller never answers). ign_at re-pulses srst_req while busy.
  task automatic run_seq(input int low_at, input int high_at, input int ign_at,
                         input int ncyc, input logic exp_wdi, input string tag);
    int         end_k;
    logic [4:0] exp;
    end_k    = (low_at >= 0) ? high_at + 3 : SW + AT;
    srst_req = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      srst_req = 1'b0;
      exp = {exp_wdi, 1'(k >= SW), 1'(k < end_k),
             1'((low_at >= 0) && (k == end_k)), 1'((low_at < 0) && (k >= end_k))};
      check($sformatf("%s k=%0d", tag, k), exp);
      if (k == low_at)  rst_n = 1'b0;
      if (k == high_at) rst_n = 1'b1;
      if (k == ign_at)  srst_req = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b01000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b11000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b11000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b01000};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b01000};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b11000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 200, 5'b11000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1,   1, 5'b01000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b01000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b11000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1,   1, 5'b11000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 600, 5'b11000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b11000};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b01000};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b01000};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1,   1, 5'b11000};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 499, 5'b11000};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b01000};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 250, 5'b01000};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 100, 5'b01000};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 501, 5'b01000};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1,   1, 5'b11000};

    rst      = 1'b1;
    en_kick  = 1'b1;
    kick_req = 1'b0;
    srst_req = 1'b0;
    rst_n    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", 5'b01000);
    rst = 1'b0;

    // Kick period, kick_req, enable gating, simultaneous expiry, rst_n freeze.
    for (int i = 0; i < NV; i++) begin
      en_kick  = vecs[i].en_kick;
      kick_req = vecs[i].kick_req;
      srst_req = vecs[i].srst_req;
      rst_n    = vecs[i].rst_n;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(posedge clk);
        @(negedge clk);
        kick_req = 1'b0;
        srst_req = 1'b0;
      end
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    en_kick = 1'b0;
    // Controller already in reset before ASSERT ends; extra srst_req while busy is ignored.
    run_seq(5, 25, 15, 40, 1'b1, "seq_early_ack");
    // Controller answers during WAIT_ACK.
    run_seq(15, 40, -1, 50, 1'b1, "seq_late_ack");
    // Controller never answers: timeout sets err, no done.
    run_seq(-1, -1, -1, SW + AT + 10, 1'b1, "seq_timeout");

    // New request clears err; rst mid-ASSERT aborts asynchronously.
    srst_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst_req = 1'b0;
    check("abort_start", 5'b10100);
    repeat (2) @(negedge clk);
    check("abort_assert", 5'b10100);
    rst = 1'b1;
    #1;
    check("abort_async", 5'b01000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check($sformatf("abort_after k=%0d", k), 5'b01000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
